// File: rtl/ising_pkg.sv
// Shared types and constants for the Ising Metropolis sweep controller.
// Holds the FSM state encoding, acceptance thresholds and LFSR feedback mask.
package ising_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [11:0] THR_0 = 12'd4095;
    localparam logic [11:0] THR_2 = 12'd554;
    localparam logic [11:0] THR_4 = 12'd75;

    localparam int DE_W = 5;
    localparam logic signed [DE_W-1:0] E_ZERO = 5'sd0;
    localparam logic signed [DE_W-1:0] E_TWO  = 5'sd2;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // e is 2*dE, so only {-4,-2,0,2,4} occur; anything above 2 is the e=4 case.
    function automatic logic [11:0] accept_threshold(input logic signed [DE_W-1:0] e);
        if (e <= E_ZERO) begin
            return THR_0;
        end else if (e == E_TWO) begin
            return THR_2;
        end
        return THR_4;
    endfunction

endpackage

// File: rtl/ising_sweep_ctrl_if.sv
// Host-side run control, statistics and lattice read port of the sweep controller.
// Handshake: start is a level sampled only while the controller is idle; busy/done report progress.
interface ising_sweep_ctrl_if #(
    parameter int N = 8
);
    import ising_pkg::*;

    localparam int AW = $clog2(N);
    localparam int MW = $clog2(N * N) + 2;

    logic                 start;
    logic [15:0]          num_sweeps;
    logic                 busy;
    logic                 done;
    logic [31:0]          flip_count;
    logic signed [MW-1:0] magnetization;
    logic [2*AW-1:0]      rd_addr;
    logic                 rd_spin;
    state_t               state;
    logic [15:0]          lfsr_dbg;

    modport master (
        output start, num_sweeps, rd_addr,
        input  busy, done, flip_count, magnetization, rd_spin, state, lfsr_dbg
    );

    modport slave (
        input  start, num_sweeps, rd_addr,
        output busy, done, flip_count, magnetization, rd_spin, state, lfsr_dbg
    );

endinterface

// File: rtl/ising_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1); advances only when step is high.
module ising_lfsr16
    import ising_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] state
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/ising_sweep_ctrl.sv
// Metropolis sweep sequencer: raster-order EVAL/COMMIT over an NxN periodic lattice
// held in registers, with flip statistics and a combinational lattice read port.
module ising_sweep_ctrl
    import ising_pkg::*;
#(
    parameter int          N    = 8,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    ising_sweep_ctrl_if.slave  bus
);

    localparam int AW = $clog2(N);
    localparam int NN = N * N;
    localparam int MW = $clog2(NN) + 2;

    localparam logic [AW-1:0]        ONE      = AW'(1);
    localparam logic [AW-1:0]        LAST     = '1;
    localparam logic signed [MW-1:0] MAG_INIT = MW'(NN);
    localparam logic signed [MW-1:0] MAG_TWO  = MW'(2);

    state_t               state_q, state_d;
    logic [NN-1:0]        spin_q, spin_d;
    logic [AW-1:0]        row_q, row_d, col_q, col_d;
    logic [15:0]          sweep_q, sweep_d, sweeps_q, sweeps_d;
    logic                 accept_q, accept_d;
    logic [31:0]          flip_q, flip_d;
    logic signed [MW-1:0] mag_q, mag_d;

    logic        lfsr_step;
    logic [15:0] lfsr;

    ising_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (lfsr_step),
        .state (lfsr)
    );

    logic [2*AW-1:0]       site_idx;
    logic                  s, n_up, n_dn, n_lf, n_rt;
    logic [2:0]            up_cnt;
    logic signed [DE_W-1:0] nb, e_idx;
    logic [11:0]           thr;
    logic                  accept_now;
    logic                  busy, done;

    // Power-of-two side lets plain AW-bit arithmetic provide the periodic wrap.
    always_comb begin
        site_idx   = {row_q, col_q};
        s          = spin_q[site_idx];
        n_up       = spin_q[{row_q - ONE, col_q}];
        n_dn       = spin_q[{row_q + ONE, col_q}];
        n_lf       = spin_q[{row_q, col_q - ONE}];
        n_rt       = spin_q[{row_q, col_q + ONE}];
        up_cnt     = {2'b00, n_up} + {2'b00, n_dn} + {2'b00, n_lf} + {2'b00, n_rt};
        nb         = $signed({1'b0, up_cnt, 1'b0}) - 5'sd4;
        e_idx      = s ? nb : -nb;
        thr        = accept_threshold(e_idx);
        accept_now = (lfsr[11:0] <= thr);
    end

    always_comb begin
        state_d   = state_q;
        spin_d    = spin_q;
        row_d     = row_q;
        col_d     = col_q;
        sweep_d   = sweep_q;
        sweeps_d  = sweeps_q;
        accept_d  = accept_q;
        flip_d    = flip_q;
        mag_d     = mag_q;
        lfsr_step = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sweeps_d = bus.num_sweeps;
                    sweep_d  = '0;
                    state_d  = (bus.num_sweeps == 16'd0) ? DONE : EVAL;
                end
            end
            EVAL: begin
                busy      = 1'b1;
                accept_d  = accept_now;
                lfsr_step = 1'b1;
                state_d   = COMMIT;
            end
            COMMIT: begin
                busy    = 1'b1;
                state_d = EVAL;
                if (accept_q) begin
                    spin_d[site_idx] = ~s;
                    flip_d           = flip_q + 32'd1;
                    mag_d            = s ? (mag_q - MAG_TWO) : (mag_q + MAG_TWO);
                end
                col_d = col_q + ONE;
                if (col_q == LAST) begin
                    row_d = row_q + ONE;
                    if (row_q == LAST) begin
                        sweep_d = sweep_q + 16'd1;
                        if (sweep_q == sweeps_q - 16'd1) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            spin_q   <= '1;
            row_q    <= '0;
            col_q    <= '0;
            sweep_q  <= '0;
            sweeps_q <= '0;
            accept_q <= 1'b0;
            flip_q   <= '0;
            mag_q    <= MAG_INIT;
        end else begin
            state_q  <= state_d;
            spin_q   <= spin_d;
            row_q    <= row_d;
            col_q    <= col_d;
            sweep_q  <= sweep_d;
            sweeps_q <= sweeps_d;
            accept_q <= accept_d;
            flip_q   <= flip_d;
            mag_q    <= mag_d;
        end
    end

    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.flip_count    = flip_q;
    assign bus.magnetization = mag_q;
    assign bus.rd_spin       = spin_q[bus.rd_addr];
    assign bus.state         = state_q;
    assign bus.lfsr_dbg      = lfsr;

endmodule

// File: tb/tb_ising_sweep_ctrl.sv
// Bench for ising_sweep_ctrl: N=4 and N=8 instances against a site-by-site Metropolis model.
module tb_ising_sweep_ctrl;
    import ising_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ising_sweep_ctrl_if #(.N(4)) bus4 ();
    ising_sweep_ctrl_if #(.N(8)) bus8 ();

    ising_sweep_ctrl #(.N(4), .SEED(16'hACE1)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    ising_sweep_ctrl #(.N(8), .SEED(16'hACE1)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int checks = 0;
    int errors = 0;

    logic        busy_v[2], done_v[2], spin_v[2];
    logic [31:0] flip_v[2];
    int          mag_v[2];
    state_t      st_v[2];

    always_comb begin
        busy_v[0] = bus4.busy;  busy_v[1] = bus8.busy;
        done_v[0] = bus4.done;  done_v[1] = bus8.done;
        spin_v[0] = bus4.rd_spin; spin_v[1] = bus8.rd_spin;
        flip_v[0] = bus4.flip_count; flip_v[1] = bus8.flip_count;
        mag_v[0]  = int'(bus4.magnetization);
        mag_v[1]  = int'(bus8.magnetization);
        st_v[0]   = bus4.state; st_v[1] = bus8.state;
    end

    // ---------------- reference model ----------------
    bit          mlat[2][1024];
    int unsigned mlfsr[2];
    int unsigned mflips[2];
    int          mmag[2];
    int          cov[4];

    function automatic int nsz(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    function automatic int sp(input int d, input int r, input int c);
        return mlat[d][r * nsz(d) + c] ? 1 : -1;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 1024; i++) mlat[d][i] = 1'b1;
            mlfsr[d]  = 32'hACE1;
            mflips[d] = 0;
            mmag[d]   = nsz(d) * nsz(d);
        end
    endfunction

    function automatic void model_site(input int d, input int idx);
        int n, r, c, s, nb, de, rnd, thr;
        n   = nsz(d);
        r   = idx / n;
        c   = idx % n;
        s   = sp(d, r, c);
        nb  = sp(d, (r + n - 1) % n, c) + sp(d, (r + 1) % n, c)
            + sp(d, r, (c + n - 1) % n) + sp(d, r, (c + 1) % n);
        de  = s * nb / 2;
        rnd = int'(mlfsr[d] % 4096);
        thr = (de <= 0) ? 4095 : ((de == 1) ? 554 : 75);
        if (de == 2 && rnd == 75)  cov[0]++;
        if (de == 2 && rnd == 76)  cov[1]++;
        if (de == 1 && rnd == 554) cov[2]++;
        if (de == 1 && rnd == 555) cov[3]++;
        if (rnd <= thr) begin
            mlat[d][idx] = !mlat[d][idx];
            mflips[d]++;
            mmag[d] += mlat[d][idx] ? 2 : -2;
        end
        if (mlfsr[d] % 2 == 1) mlfsr[d] = (mlfsr[d] / 2) ^ 32'hB400;
        else                   mlfsr[d] = mlfsr[d] / 2;
    endfunction

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int d, input logic st, input logic [15:0] ns);
        if (d == 0) begin bus4.start = st; bus4.num_sweeps = ns; end
        else        begin bus8.start = st; bus8.num_sweeps = ns; end
    endtask

    task automatic set_addr(input int d, input int a);
        if (d == 0) bus4.rd_addr = 4'(a);
        else        bus8.rd_addr = 6'(a);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Reads every site, compares to the model, and checks M = 2*#ones - N*N.
    task automatic check_lattice(input int d);
        int nn, ones;
        nn   = nsz(d) * nsz(d);
        ones = 0;
        for (int a = 0; a < nn; a++) begin
            set_addr(d, a);
            #1;
            check($sformatf("rd_spin[%0d][%0d]", d, a), spin_v[d], mlat[d][a]);
            if (mlat[d][a]) ones++;
        end
        check("mag_vs_ones", mag_v[d], 2 * ones - nn);
        @(negedge clk);
    endtask

    // Starts a run and follows it cycle by cycle; returns in the IDLE cycle after DONE.
    task automatic run(input int d, input int s, input int exp_done, input int exp_busy,
                       input bit noisy);
        int nn, cyc, done_at, busy_n, site, a;
        nn = nsz(d) * nsz(d);
        drive(d, 1'b1, 16'(s));
        @(negedge clk);
        drive(d, 1'b0, 16'd0);
        done_at = -1; busy_n = 0; site = 0; cyc = 1;
        while (done_at < 0 && cyc <= exp_done + 4) begin
            if (busy_v[d]) busy_n++;
            if (done_v[d]) done_at = cyc;
            if (cyc >= 3 && cyc % 2 == 1 && site < nn * s) begin
                model_site(d, site % nn);
                site++;
                check("flip_count", longint'(flip_v[d]), longint'(mflips[d]));
                check("magnetization", mag_v[d], mmag[d]);
                a = $urandom_range(0, nn - 1);
                set_addr(d, a);
                #1;
                check("rd_spin_run", spin_v[d], mlat[d][a]);
            end
            if (noisy && cyc < exp_busy)
                drive(d, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 5)));
            else
                drive(d, 1'b0, 16'd0);
            @(negedge clk);
            cyc++;
        end
        check("done_cycle", done_at, exp_done);
        check("busy_cycles", busy_n, exp_busy);
        check("done_low_after", done_v[d], 0);
        check("busy_low_after", busy_v[d], 0);
        check("state_idle_after", st_v[d], IDLE);
        check("flip_after", longint'(flip_v[d]), longint'(mflips[d]));
        check("mag_after", mag_v[d], mmag[d]);
    endtask

    typedef struct {
        int d;
        int sweeps;
        int exp_done;
        int exp_busy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, s, n, cyc;
        drive(0, 1'b0, 16'd0);
        drive(1, 1'b0, 16'd0);
        set_addr(0, 0);
        set_addr(1, 0);
        for (int i = 0; i < 4; i++) cov[i] = 0;

        vecs[0] = '{0, 0, 1, 0};
        vecs[1] = '{0, 1, 33, 32};
        vecs[2] = '{0, 2, 65, 64};
        vecs[3] = '{0, 0, 1, 0};
        vecs[4] = '{1, 0, 1, 0};
        vecs[5] = '{1, 1, 129, 128};

        // Reset state
        do_reset();
        check("rst_busy", busy_v[0], 0);
        check("rst_done", done_v[0], 0);
        check("rst_flip", longint'(flip_v[0]), 0);
        check("rst_mag4", mag_v[0], 16);
        check("rst_mag8", mag_v[1], 64);
        check("rst_state", st_v[0], IDLE);
        check_lattice(0);

        // Table-driven runs, issued back to back
        for (int i = 0; i < 6; i++) begin
            run(vecs[i].d, vecs[i].sweeps, vecs[i].exp_done, vecs[i].exp_busy, 1'b0);
        end
        check_lattice(0);
        check_lattice(1);

        // Golden run: N=8 from reset, 10 sweeps
        do_reset();
        run(1, 10, 2 * 64 * 10 + 1, 2 * 64 * 10, 1'b0);
        check_lattice(1);

        // Abort: reset in cycle 10 of a run that starts from a disordered lattice
        drive(1, 1'b1, 16'd2);
        @(negedge clk);
        drive(1, 1'b0, 16'd0);
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("abort_busy", busy_v[1], 0);
        check("abort_done", done_v[1], 0);
        check("abort_flip", longint'(flip_v[1]), 0);
        check("abort_mag", mag_v[1], 64);
        check("abort_state", st_v[1], IDLE);
        for (int k = 0; k < 6; k++) begin
            check("abort_no_done", done_v[1], 0);
            @(negedge clk);
        end
        check_lattice(1);

        // Randomized runs with start noise while busy
        for (int i = 0; i < 6; i++) begin
            d = $urandom_range(0, 1);
            s = $urandom_range(0, 3);
            n = nsz(d);
            run(d, s, 2 * n * n * s + 1, 2 * n * n * s, 1'b1);
            check_lattice(d);
        end

        $display("cover e4_r75=%0d e4_r76=%0d e2_r554=%0d e2_r555=%0d",
                 cov[0], cov[1], cov[2], cov[3]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ising_sweep_ctrl.md
# ising_sweep_ctrl

Sequencer for Metropolis Monte-Carlo sweeps over an N×N 2D Ising lattice with periodic boundaries. Holds the lattice in on-chip registers and visits sites in raster order. For each site it computes the local energy index, draws a 12-bit pseudo-random number, applies the fixed-temperature acceptance thresholds, and commits the flip. It sits between the host control/status registers and the spin-update datapath, and exposes run control, statistics and a lattice read port.

## Interface
- `N`, default 8: lattice side; power of two, 4..32.
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `start` in 1: run request, sampled only in IDLE.
- `num_sweeps` in 16: sweeps to run, latched on accepted `start`.
- `busy` out 1: high from the cycle after accepted `start` until DONE.
- `done` out 1: one-cycle pulse on run completion.
- `flip_count` out 32: accepted flips since reset; wraps at 2^32.
- `magnetization` out clog2(N*N)+2, signed: sum of all spins.
- `rd_addr` in 2*clog2(N): host read address, {row,col}.
- `rd_spin` out 1: combinational read of the lattice; 1 = +1, 0 = −1.

## Operation
- Reset:
  - all spins = 1;
  - `flip_count` = 0, `magnetization` = +N*N;
  - LFSR = `SEED`;
  - `busy` = 0, `done` = 0;
  - state = IDLE, row/col/sweep counters = 0.
- States:
  - **IDLE**: `start`=1 latches `num_sweeps`. If the latched value is 0, go to DONE; otherwise go to EVAL.
  - **EVAL**, one cycle per site:
    - s = ±1 spin at (row,col); nb = sum of the four ±1 neighbours, indices mod N (wrap-around).
    - dE = s*nb/2, in {−2,−1,0,1,2}. Encode it as a 5-bit signed index e = 2*dE, in {−4,−2,0,2,4}.
    - Threshold: e≤0 → 4095; e=2 → 554; e=4 → 75.
    - accept = (lfsr[11:0] ≤ threshold). Register accept, then step the LFSR.
    - Go to COMMIT.
  - **COMMIT**:
    - If accept: invert the spin, increment `flip_count`, and add ∓2 to `magnetization` (new spin −1 → −2; new spin +1 → +2).
    - Advance col; on col wrap, advance row; on row wrap, advance the sweep counter.
    - If that was the last site of the last sweep, go to DONE; else go to EVAL.
  - **DONE**: `done`=1 for this cycle only. Clear `busy` and return to IDLE.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Steps exactly once per EVAL and holds otherwise.
- Sites updated earlier in a sweep are visible to later sites in the same sweep (sequential Metropolis).
- `start` is ignored while `busy`=1.
- `rd_spin` is valid at all times. During a run it reflects the current, partially-updated lattice.
- `rst` mid-run aborts immediately: no `done` pulse, and every reset value is restored on the next edge.

## Timing
- Site cost: 2 cycles. Run latency: `start` sampled at edge k → `done`=1 in cycle k+2·N²·S+1, where S = num_sweeps.
- num_sweeps=0: `done` in cycle k+1; `busy` never asserts; no state change.
- Spin, `flip_count` and `magnetization` all update on the COMMIT edge, together and consistently.
- Back-to-back runs: a new `start` is accepted in the IDLE cycle that follows DONE.

## Structure
- Shared package `ising_pkg` holds:
  - state enum {IDLE, EVAL, COMMIT, DONE};
  - constants THR_0=12'd4095, THR_2=12'd554, THR_4=12'd75;
  - dE index width (5);
  - polynomial tap mask 16'hB400.
- Sub-module `ising_lfsr16` (clk, rst, step, seed parameter, 16-bit state out). The controller keeps the FSM, lattice array, neighbour mux, acceptance compare and counters.

## Test plan
- **Reset**, N=4: `busy`=0, `done`=0, `flip_count`=0, `magnetization`=16, `rd_spin`=1 at all 16 addresses.
- **Zero sweeps**: num_sweeps=0 and `start` at edge k → `done` in k+1, `busy` stays 0, counters unchanged.
- **Latency**: N=4, num_sweeps=1 → `done` exactly at k+33, and `busy` high for cycles k+1..k+32.
- **Golden model**: N=8, SEED 16'hACE1, 10 sweeps. Lattice, `flip_count` and `magnetization` match the bit-exact software model. Assert `magnetization` = 2·(#ones)−64 at every cycle.
- **Ignored start / abort**: `start` pulsed while busy → no effect on sweep count. `rst` in cycle 10 of a run → next cycle shows all spins 1, counters 0, IDLE, and no `done`.
- **Acceptance bound**: an assertion checks every COMMIT with accept=1 against the rule. Cover hits for e=4 with random = 75 (accept) and 76 (reject), and for e=2 with random = 554 and 555.
